uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised successor to the fixed 8N1 UART transmitter. It serialises one word per valid/ready handshake. Data width, parity mode, stop-bit count and inter-frame gap are configurable. The baud-rate divider is internal, so the whole block runs on the system clock with no derived clock. It sits between the ADC sample formatter and the board UART pin.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s; localparam BAUD_DIV = CLK_FREQ/BAUD (integer truncation), must be >= 2
DATA_BITS, 8, payload bits per frame, legal range 5..9
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame, legal values 1 or 2
IDLE_GAP, 0, extra mark (high) bit periods after the stop bits, range 0..15

Ports:
RST_clk  in  1  system clock; all logic on its rising edge
RST_n  in  1  synchronous active-low reset
tx_data  in  DATA_BITS  word to send; sampled only at the accept edge
tx_valid  in  1  producer has a word available
tx_ready  out  1  block can accept a word this cycle
uart_tx_data  out  1  serial line, registered output, idle high
uart_busy  out  1  high while a frame, including any gap, is in progress
frame_done  out  1  one-cycle pulse when a frame (including gap) completes

Behaviour:
- Clock and reset: one clock, RST_clk. Reset is synchronous and active-low on RST_n.
- Reset (RST_n low at a rising edge): uart_tx_data=1, tx_ready=0, uart_busy=0, frame_done=0, state=IDLE, all counters cleared.
- tx_ready is high in the first cycle after reset release.
- States: IDLE, START, DATA, PARITY, STOP, GAP.
- IDLE:
  - tx_ready=1, uart_busy=0, line=1.
  - An accept occurs at a rising edge where tx_valid=1 and tx_ready=1. At that edge: latch tx_data into a shift register, clear the baud counter and bit counter, go to START.
  - tx_valid without tx_ready has no effect.
- Latency: the line goes low at the edge after the accept edge. tx_ready and uart_busy change at that same edge.
- Bit timing: each bit period lasts exactly BAUD_DIV clocks. The baud counter counts 0..BAUD_DIV-1, and the state/bit advances when the counter equals BAUD_DIV-1.
- START: line=0 for one bit period, then go to DATA.
- DATA:
  - Send DATA_BITS bits, LSB first, from the latched copy.
  - Changes on tx_data during the frame are ignored.
  - After the last bit: go to PARITY if PARITY!=0, otherwise go to STOP.
- PARITY:
  - Even parity: line = XOR of the latched data bits.
  - Odd parity: line = inverse of that XOR.
  - Lasts one bit period, then go to STOP.
- STOP: line=1 for STOP_BITS bit periods. Then go to GAP if IDLE_GAP>0, otherwise go to IDLE.
- GAP: line=1 for IDLE_GAP bit periods, then go to IDLE.
- uart_busy is high in every state except IDLE. tx_ready equals (state==IDLE) and is not asserted during reset.
- frame_done:
  - High for exactly one cycle: the first IDLE cycle after a frame.
  - Coincides with tx_ready rising.
  - Never asserted after reset alone.
- Back-to-back: with tx_valid held high, the next accept happens in the first IDLE cycle. Accept edges are therefore spaced FRAME_BITS*BAUD_DIV+1 clocks apart, where FRAME_BITS = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS + IDLE_GAP.
- Reset mid-frame:
  - Line returns high at the reset edge.
  - The partial frame is abandoned and is never resumed or re-sent.
  - frame_done is not pulsed.
- Illegal parameter values (DATA_BITS out of range, PARITY>2, STOP_BITS not 1 or 2, BAUD_DIV<2): flagged in simulation with $error. Synthesis behaviour is undefined.
- Counter widths: baud counter is $clog2(BAUD_DIV) bits; bit counter is 4 bits.

Test Plan:
All scenarios use CLK_FREQ=1000000 and BAUD=100000, giving BAUD_DIV=10.
1. 8N1 (PARITY=0, STOP_BITS=1), send 0xA5.
   - Line, one value per 10 clocks: 0,1,0,1,0,0,1,0,1,1.
   - uart_busy high for exactly 100 clocks.
   - frame_done pulses once at clock 101 after accept.
2. Even parity, send 0xA5 -> parity bit 0. Odd parity, send 0xA5 -> parity bit 1. Odd parity, send 0x01 -> parity bit 0. Each frame is 110 clocks.
3. DATA_BITS=7, STOP_BITS=2, send 0x41 -> line 0,1,0,0,0,0,0,1,1,1 (10 bits, 100 clocks). Bits above bit 6 of tx_data are ignored.
4. 8N1 with tx_valid held high and words 0x00 then 0xFF.
   - Accept edges are 101 clocks apart.
   - Line stays high exactly 1 clock between the 0xFF frame's stop bit and the next start bit.
   - Toggling tx_data mid-frame does not change the serialised bits.
5. IDLE_GAP=3: after the stop bit, line stays high 30 clocks with uart_busy=1. tx_ready rises at clock 131.
6. Reset asserted at clock 45 of a 0x00 frame.
   - Next edge: line=1, tx_ready=0, busy=0, and no frame_done.
   - After release: tx_ready=1, and a fresh frame sends correctly.

Source files
------------

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: one word per valid/ready handshake, framed
// as start + DATA_BITS (LSB first) + optional parity + STOP_BITS + IDLE_GAP,
// all timed by an internal baud divider running on the system clock.
module uart_tx_frame #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int IDLE_GAP  = 0
) (
  input  logic                 RST_clk,
  input  logic                 RST_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 uart_tx_data,
  output logic                 uart_busy,
  output logic                 frame_done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W    = (BAUD_DIV >= 2) ? $clog2(BAUD_DIV) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);
  localparam logic [3:0]       GAP_LAST   = 4'(IDLE_GAP - 1);
  localparam logic             PARITY_ODD = (PARITY == 2);

  // Parameter sanity: elaboration-time errors for configurations the
  // framing logic was never meant to handle.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS=%0d outside 5..9", DATA_BITS);
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY=%0d not 0, 1 or 2", PARITY);
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS=%0d not 1 or 2", STOP_BITS);
  end
  if (IDLE_GAP < 0 || IDLE_GAP > 15) begin : g_bad_idle_gap
    $error("uart_tx_frame: IDLE_GAP=%0d outside 0..15", IDLE_GAP);
  end
  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $error("uart_tx_frame: BAUD_DIV=%0d must be >= 2", BAUD_DIV);
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     baud_q;
  logic [CNT_W-1:0]     baud_d;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 line_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 baud_tick;

  // Baud divider: the tick marks the last clock of the current bit period.
  assign baud_tick = (baud_q == BAUD_LAST);
  assign baud_d    = baud_tick ? '0 : baud_q + 1'b1;

  // Frame sequencer with registered line, handshake and status outputs.
  // NOTE: every state register uses <= so all of them update from the same
  // pre-edge values; a blocking = here would let later lines see new values.
  always_ff @(posedge RST_clk) begin
    if (!RST_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      line_q   <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          line_q  <= 1'b1;
          if (tx_valid && ready_q) begin
            shift_q  <= tx_data;
            parity_q <= (^tx_data) ^ PARITY_ODD;
            baud_q   <= '0;
            bit_q    <= '0;
            state_q  <= S_START;
            line_q   <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        S_START: begin
          baud_q <= baud_d;
          if (baud_tick) begin
            state_q <= S_DATA;
            line_q  <= shift_q[0];
          end
        end
        S_DATA: begin
          baud_q <= baud_d;
          if (baud_tick) begin
            if (bit_q == DATA_LAST) begin
              bit_q <= '0;
              if (PARITY != 0) begin
                state_q <= S_PARITY;
                line_q  <= parity_q;
              end else begin
                state_q <= S_STOP;
                line_q  <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + 4'd1;
              shift_q <= shift_q >> 1;
              line_q  <= shift_q[1];
            end
          end
        end
        S_PARITY: begin
          baud_q <= baud_d;
          if (baud_tick) begin
            state_q <= S_STOP;
            line_q  <= 1'b1;
          end
        end
        S_STOP: begin
          baud_q <= baud_d;
          if (baud_tick) begin
            if (bit_q == STOP_LAST) begin
              bit_q <= '0;
              if (IDLE_GAP > 0) begin
                state_q <= S_GAP;
              end else begin
                state_q <= S_IDLE;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end
        end
        S_GAP: begin
          baud_q <= baud_d;
          if (baud_tick) begin
            if (bit_q == GAP_LAST) begin
              bit_q   <= '0;
              state_q <= S_IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          line_q  <= 1'b1;
        end
      endcase
    end
  end

  assign tx_ready     = ready_q;
  assign uart_tx_data = line_q;
  assign uart_busy    = busy_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: five differently configured instances share one
// clock and reset; a frame-level model predicts every output cycle by cycle,
// and directed scenarios add hand-computed literal expectations.
module tb_uart_tx_frame;

  localparam int N = 5;
  localparam int CFG_DB  [N] = '{8, 8, 8, 7, 8};
  localparam int CFG_PAR [N] = '{0, 1, 2, 0, 0};
  localparam int CFG_SB  [N] = '{1, 1, 1, 2, 1};
  localparam int CFG_GAP [N] = '{0, 0, 0, 0, 3};

  logic         clk = 1'b0;
  logic         rst_n;
  logic [8:0]   txd [N];
  logic [N-1:0] vld, rdy, line, busy, done;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .IDLE_GAP(0)) u_8n1 (
    .RST_clk(clk), .RST_n(rst_n), .tx_data(txd[0][7:0]), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .uart_tx_data(line[0]), .uart_busy(busy[0]), .frame_done(done[0]));

  uart_tx_frame #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .IDLE_GAP(0)) u_8e1 (
    .RST_clk(clk), .RST_n(rst_n), .tx_data(txd[1][7:0]), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .uart_tx_data(line[1]), .uart_busy(busy[1]), .frame_done(done[1]));

  uart_tx_frame #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .IDLE_GAP(0)) u_8o1 (
    .RST_clk(clk), .RST_n(rst_n), .tx_data(txd[2][7:0]), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .uart_tx_data(line[2]), .uart_busy(busy[2]), .frame_done(done[2]));

  uart_tx_frame #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(0),
                  .STOP_BITS(2), .IDLE_GAP(0)) u_7n2 (
    .RST_clk(clk), .RST_n(rst_n), .tx_data(txd[3][6:0]), .tx_valid(vld[3]),
    .tx_ready(rdy[3]), .uart_tx_data(line[3]), .uart_busy(busy[3]), .frame_done(done[3]));

  uart_tx_frame #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .IDLE_GAP(3)) u_gap3 (
    .RST_clk(clk), .RST_n(rst_n), .tx_data(txd[4][7:0]), .tx_valid(vld[4]),
    .tx_ready(rdy[4]), .uart_tx_data(line[4]), .uart_busy(busy[4]), .frame_done(done[4]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line value for each bit period of a frame, index 0 = start bit;
  // everything past the payload/parity is mark (1).
  function automatic logic [31:0] frame_bits(input logic [8:0] d, input int db,
                                             input int par);
    logic [31:0] b = '1;
    logic        p = 1'b0;
    b[0] = 1'b0;
    for (int j = 0; j < db; j++) begin
      b[1+j] = d[j];
      p      = p ^ d[j];
    end
    if (par != 0) b[1+db] = (par == 1) ? p : ~p;
    return b;
  endfunction

  function automatic int frame_len(input int i);
    return 1 + CFG_DB[i] + ((CFG_PAR[i] != 0) ? 1 : 0) + CFG_SB[i] + CFG_GAP[i];
  endfunction

  // Frame-level model: 0 = in reset / just released, 1 = idle, 2 = sending,
  // k counts clocks since the accept edge (1 = first start-bit clock).
  int          m_mode [N] = '{default: 0};
  int          m_k    [N] = '{default: 0};
  int          m_n    [N] = '{default: 0};
  logic [31:0] m_bits [N] = '{default: '1};
  logic        m_done [N] = '{default: 1'b0};

  // Model advance on every rising edge from the same inputs the DUTs see.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        m_mode[i] <= 0;
        m_done[i] <= 1'b0;
      end else begin
        case (m_mode[i])
          0: m_mode[i] <= 1;
          1: begin
            m_done[i] <= 1'b0;
            if (vld[i]) begin
              m_mode[i] <= 2;
              m_k[i]    <= 1;
              m_bits[i] <= frame_bits(txd[i], CFG_DB[i], CFG_PAR[i]);
              m_n[i]    <= frame_len(i);
            end
          end
          default: begin
            if (m_k[i] == m_n[i] * 10) begin
              m_mode[i] <= 1;
              m_done[i] <= 1'b1;
            end else begin
              m_k[i] <= m_k[i] + 1;
            end
          end
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        logic exp_line;
        exp_line = (m_mode[i] == 2) ? m_bits[i][(m_k[i] - 1) / 10] : 1'b1;
        check($sformatf("line%0d", i),  32'(line[i]), 32'(exp_line));
        check($sformatf("ready%0d", i), 32'(rdy[i]),  32'(m_mode[i] == 1));
        check($sformatf("busy%0d", i),  32'(busy[i]), 32'(m_mode[i] == 2));
        check($sformatf("done%0d", i),  32'(done[i]), 32'(m_done[i]));
      end
    end
  end

  // Present a word on instance i and return right after the accept edge.
  task automatic send(input int i, input logic [8:0] d);
    bit ok = 1'b0;
    @(negedge clk);
    txd[i] = d;
    vld[i] = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (rdy[i]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1 vld[i] = 1'b0;
    end else begin
      vld[i] = 1'b0;
      check($sformatf("send_timeout%0d", i), 32'd0, 32'd1);
    end
  endtask

  // Sample instance i for ncyc clocks after an accept: mid-bit line values,
  // busy clock count, and the cycle where frame_done / tx_ready first appear.
  task automatic observe(input int i, input int ncyc, output logic [31:0] seq,
                         output int busy_cnt, output int done_k, output int ready_k);
    seq = '1; busy_cnt = 0; done_k = 0; ready_k = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k % 10 == 5 && k / 10 < 32) seq[k/10] = line[i];
      if (busy[i]) busy_cnt++;
      if (done[i] && done_k == 0) done_k = k;
      if (rdy[i] && ready_k == 0) ready_k = k;
    end
  endtask

  initial begin
    logic [31:0] seq, pin;
    int          bc, dk, rk;
    int          acc [3];
    logic [8:0]  words [3];
    logic        la, lb;
    int          n;

    rst_n = 1'b0;
    vld   = '0;
    for (int i = 0; i < N; i++) txd[i] = '0;

    // Pin the model's framing against hand-derived patterns.
    pin = frame_bits(9'h0A5, 8, 0);
    check("model_8n1_a5", 32'(pin[9:0]), 32'(10'b1101001010));
    pin = frame_bits(9'h001, 8, 2);
    check("model_odd_01_parity", 32'(pin[9]), 32'd0);

    // Reset state.
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'(rdy[0]), 32'd0);
    check("reset_line",  32'(line[0]), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(rdy[0]), 32'd1);
    check("no_done_after_reset", 32'(done), 32'd0);

    // 8N1, 0xA5.
    send(0, 9'h0A5);
    observe(0, 110, seq, bc, dk, rk);
    check("t1_line", 32'(seq[9:0]), 32'(10'b1101001010));
    check("t1_busy_clocks", bc, 100);
    check("t1_done_clock", dk, 101);

    // Parity variants.
    send(1, 9'h0A5);
    observe(1, 115, seq, bc, dk, rk);
    check("t2_even_a5_parity", 32'(seq[9]), 32'd0);
    check("t2_even_busy", bc, 110);
    send(2, 9'h0A5);
    observe(2, 115, seq, bc, dk, rk);
    check("t2_odd_a5_parity", 32'(seq[9]), 32'd1);
    check("t2_odd_done", dk, 111);
    send(2, 9'h001);
    observe(2, 115, seq, bc, dk, rk);
    check("t2_odd_01_parity", 32'(seq[9]), 32'd0);

    // 7 data bits, 2 stop bits, upper tx_data bit set but ignored.
    send(3, 9'h0C1);
    observe(3, 110, seq, bc, dk, rk);
    check("t3_line", 32'(seq[9:0]), 32'(10'b1110000010));
    check("t3_busy_clocks", bc, 100);

    // Idle gap of three bit periods.
    send(4, 9'h05A);
    observe(4, 140, seq, bc, dk, rk);
    check("t5_busy_clocks", bc, 130);
    check("t5_ready_rise", rk, 131);
    check("t5_gap_line", 32'(seq[12:10]), 32'b111);

    // Back-to-back with valid held and tx_data scrambled mid-frame.
    words[0] = 9'h000; words[1] = 9'h0FF; words[2] = 9'h03C;
    n = 0; la = 1'b0; lb = 1'b1;
    @(negedge clk);
    txd[0] = words[0];
    vld[0] = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (n == 3) begin
        lb = line[0];
        vld[0] = 1'b0;
        break;
      end
      if (rdy[0]) begin
        acc[n] = c;
        if (n == 2) la = line[0];
        txd[0] = words[n];
        n++;
      end else begin
        txd[0] = 9'($urandom);
      end
    end
    vld[0] = 1'b0;
    check("t4_accepts", n, 3);
    if (n == 3) begin
      check("t4_spacing_0", acc[1] - acc[0], 101);
      check("t4_spacing_1", acc[2] - acc[1], 101);
      check("t4_idle_line", 32'(la), 32'd1);
      check("t4_next_start", 32'(lb), 32'd0);
    end
    repeat (110) @(negedge clk);

    // Reset in the middle of a 0x00 frame.
    send(0, 9'h000);
    repeat (44) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_line",  32'(line[0]), 32'd1);
    check("t6_ready", 32'(rdy[0]),  32'd0);
    check("t6_busy",  32'(busy[0]), 32'd0);
    check("t6_done",  32'(done[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_ready_release", 32'(rdy[0]), 32'd1);
    check("t6_no_done", 32'(done[0]), 32'd0);
    send(0, 9'h03C);
    observe(0, 110, seq, bc, dk, rk);
    check("t6_fresh_line", 32'(seq[9:0]), 32'(10'b1001111000));
    check("t6_fresh_done", dk, 101);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
